bias_seq_ctrl: RTL and testbench

Sequencer that applies per-channel-group bias constants to the adder-tree output stream of a convolution layer. It holds `N_groups` bias banks, each `N_adder_tree` lanes of 18-bit fixed point; the banks are supplied as a flat constant bus from the layer's BIAS bank modules. It counts pixels and output-channel groups, selects the active bank, performs a saturating lane-wise add, and forwards results through a registered valid/ready output stage. It sits between the adder tree and the activation/requantize stage of each layer.

---
 rtl/bias_seq_ctrl_pkg.sv | 19 +
 rtl/bias_sat_add.sv | 22 ++
 rtl/bias_seq_ctrl.sv | 133 +++++++++++++
 tb/tb_bias_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared layer constants for the bias sequencer: lane width, saturation limits
// and the pass-sequencing state encoding.
package bias_seq_ctrl_pkg;

   localparam int unsigned BIAS_W = 18;
   localparam int unsigned SUM_W  = BIAS_W + 1;

   typedef logic [BIAS_W-1:0] lane_t;

   localparam lane_t SAT_MAX = 18'h1FFFF;
   localparam lane_t SAT_MIN = 18'h20000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

endpackage

// File: rtl/bias_sat_add.sv
// One lane of the bias stage: sign-extend both operands, add, clamp to the
// signed 18-bit range.
module bias_sat_add
   import bias_seq_ctrl_pkg::*;
(
   input  lane_t in_lane,
   input  lane_t bias_lane,
   output lane_t sum_c
);

   logic [SUM_W-1:0] sum_wide;

   // Overflow shows up as a disagreement between the guard bit and the 18-bit sign.
   always_comb begin
      sum_wide = {in_lane[BIAS_W-1], in_lane} + {bias_lane[BIAS_W-1], bias_lane};
      sum_c    = sum_wide[BIAS_W-1:0];
      if (sum_wide[SUM_W-1] != sum_wide[BIAS_W-1]) begin
         sum_c = sum_wide[SUM_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias sequencer: counts pixels and channel groups over one layer pass, adds the
// active bank to each adder-tree beat and registers the result for downstream.
module bias_seq_ctrl
   import bias_seq_ctrl_pkg::*;
#(
   parameter  int unsigned N_adder_tree = 16,
   parameter  int unsigned N_groups     = 4,
   parameter  int unsigned N_pixels     = 49,
   localparam int unsigned GRP_W        = (N_groups > 1) ? $clog2(N_groups) : 1,
   localparam int unsigned DATA_W       = N_adder_tree * BIAS_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_groups*DATA_W-1:0]   bias_bus,
   input  logic                         start,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_data,
   input  logic                         out_ready,
   output logic [GRP_W-1:0]             group_idx,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned PIX_W = (N_pixels > 1) ? $clog2(N_pixels) : 1;
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N_pixels - 1);
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_groups - 1);

   state_e              state_q, state_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [GRP_W-1:0]    grp_q, grp_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [DATA_W-1:0]   bias_sel;
   logic [DATA_W-1:0]   sum_all;
   logic                accept;

   // Bank select follows the group counter.
   always_comb begin
      bias_sel = bias_bus[DATA_W-1:0];
      for (int unsigned g = 0; g < N_groups; g++) begin
         if (grp_q == GRP_W'(g)) begin
            bias_sel = bias_bus[g*DATA_W +: DATA_W];
         end
      end
   end

   for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
      bias_sat_add u_sat_add (
         .in_lane   (in_data[i*BIAS_W +: BIAS_W]),
         .bias_lane (bias_sel[i*BIAS_W +: BIAS_W]),
         .sum_c     (sum_all[i*BIAS_W +: BIAS_W])
      );
   end

   // Next state, counters and the output register load/drain.
   always_comb begin
      state_d     = state_q;
      pix_d       = pix_q;
      grp_d       = grp_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      in_ready    = 1'b0;
      done        = 1'b0;
      accept      = 1'b0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pix_d   = '0;
               grp_d   = '0;
            end
         end
         RUN: begin
            in_ready = !out_valid_q || out_ready;
            accept   = in_valid && in_ready;
            if (accept) begin
               out_valid_d = 1'b1;
               out_data_d  = sum_all;
               if (pix_q == PIX_LAST) begin
                  pix_d = '0;
                  if (grp_q == GRP_LAST) begin
                     grp_d   = '0;
                     state_d = FLUSH;
                  end else begin
                     grp_d = grp_q + GRP_W'(1);
                  end
               end else begin
                  pix_d = pix_q + PIX_W'(1);
               end
            end
         end
         FLUSH: begin
            if (!out_valid_q || out_ready) begin
               state_d = IDLE;
               done    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pix_q       <= '0;
         grp_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         pix_q       <= pix_d;
         grp_q       <= grp_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign group_idx = grp_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Directed bench for bias_seq_ctrl: a beat-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_bias_seq_ctrl;
   import bias_seq_ctrl_pkg::*;

   localparam int unsigned NT    = 4;
   localparam int unsigned NG    = 2;
   localparam int unsigned NP    = 3;
   localparam int unsigned DW    = NT * 18;
   localparam int unsigned TOTAL = NG * NP;
   localparam int unsigned GW    = (NG > 1) ? $clog2(NG) : 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b1;
   logic [NG*DW-1:0] bias_bus = '0;
   logic [DW-1:0]    in_data = '0;
   logic             in_ready, out_valid, busy, done;
   logic [DW-1:0]    out_data;
   logic [GW-1:0]    group_idx;

   bias_seq_ctrl #(.N_adder_tree(NT), .N_groups(NG), .N_pixels(NP)) dut (
      .clk(clk), .rst(rst), .bias_bus(bias_bus), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .group_idx(group_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_fail = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic [17:0] sat18(input logic [17:0] a, input logic [17:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 131071) return 18'h1FFFF;
      if (s < -131072) return 18'h20000;
      return 18'(s);
   endfunction

   function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] d, input int g);
      logic [DW-1:0] r;
      for (int i = 0; i < NT; i++) r[18*i +: 18] = sat18(d[18*i +: 18], bias_bus[18*(g*NT+i) +: 18]);
      return r;
   endfunction

   // Reference model: mode 0 idle, 1 running, 2 waiting for output drain.
   int            m_mode = 0;
   int            m_beats = 0;
   bit            m_ov = 1'b0;
   logic [DW-1:0] m_od = '0;
   bit            m_acc, m_drain;

   always @(posedge clk) begin
      cyc++;
      m_acc   = (m_mode == 1) && in_valid && (!m_ov || out_ready);
      m_drain = m_ov && out_ready;
      if (rst) begin
         m_mode = 0; m_beats = 0; m_ov = 1'b0; m_od = '0;
      end else begin
         if (m_mode == 0 && start) begin
            m_mode = 1; m_beats = 0;
         end else if (m_mode == 2 && (!m_ov || out_ready)) begin
            m_mode = 0;
         end
         if (m_acc) begin
            m_od = model_sum(in_data, m_beats / NP);
            m_ov = 1'b1;
            m_beats++;
            if (m_beats == TOTAL) begin
               m_mode = 2; m_beats = 0;
            end
         end else if (m_drain) begin
            m_ov = 1'b0;
         end
      end
   end

   logic [DW-1:0] obs[$];
   int            obs_cyc[$];
   int            acc_grp[$];
   int            acc_cnt = 0;
   int            last_acc_cyc = 0;
   int            done_cyc = 0;

   // Per-cycle compare against the model and event capture.
   always @(negedge clk) begin
      if (check_en) begin
         chk("out_valid", 128'(out_valid), 128'(m_ov));
         chk("out_data", 128'(out_data), 128'(m_od));
         chk("in_ready", 128'(in_ready), 128'((m_mode == 1) && (!m_ov || out_ready)));
         chk("done", 128'(done), 128'((m_mode == 2) && (!m_ov || out_ready)));
         chk("busy", 128'(busy), 128'(m_mode != 0));
         chk("group_idx", 128'(group_idx), 128'(m_beats / NP));
         if (in_valid && in_ready) begin
            acc_cnt++; last_acc_cyc = cyc; acc_grp.push_back(int'(group_idx));
         end
         if (out_valid && out_ready) begin
            obs.push_back(out_data); obs_cyc.push_back(cyc);
         end
         if (done) done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clear_log();
      obs.delete(); obs_cyc.delete(); acc_grp.delete(); acc_cnt = 0;
   endtask

   task automatic start_pass();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic set_banks(input logic [17:0] b0, input logic [17:0] b1);
      for (int i = 0; i < NT; i++) begin
         bias_bus[18*i +: 18]      = b0;
         bias_bus[18*(NT+i) +: 18] = b1;
      end
   endtask

   task automatic send_beats(input int n, input int base, input int step, input bit sat);
      bit ok;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < NT; i++) in_data[18*i +: 18] = 18'(base + k*step);
         if (sat) begin
            in_data[17:0]  = 18'h1FF00;
            in_data[35:18] = 18'h20010;
         end
         in_valid = 1'b1;
         ok = 1'b0;
         for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk); ok = in_ready; tick();
         end
         chk("accept_timeout", 128'(ok), 128'(1));
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int w = 0; w < 100 && !idle; w++) begin
         @(negedge clk); idle = !busy;
      end
      chk("idle_timeout", 128'(idle), 128'(1));
      tick();
   endtask

   task automatic check_groups(input string nm);
      chk({nm, "_accepts"}, 128'(acc_grp.size()), 128'(TOTAL));
      for (int k = 0; k < acc_grp.size(); k++) chk({nm, "_grp"}, 128'(acc_grp[k]), 128'(k / NP));
   endtask

   logic [DW-1:0] w;

   initial begin
      @(posedge clk); #1;
      check_en = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_data", 128'(out_data), 128'(0));
      chk("rst_in_ready", 128'(in_ready), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_group_idx", 128'(group_idx), 128'(0));
      tick();
      rst = 1'b0;

      // Basic pass: bank0 +1, bank1 -2, data 5, continuous drain and accept.
      set_banks(18'd1, 18'h3FFFE);
      clear_log();
      start_pass();
      chk("t1_busy_after_start", 128'(busy), 128'(1));
      send_beats(6, 5, 0, 1'b0);
      wait_idle();
      chk("t1_beats", 128'(obs.size()), 128'(6));
      for (int k = 0; k < obs.size(); k++)
         chk("t1_beat", 128'(obs[k]), (k < 3) ? 128'({NT{18'd6}}) : 128'({NT{18'd3}}));
      chk("t1_done_latency", 128'(done_cyc - last_acc_cyc), 128'(1));
      if (obs_cyc.size() == 6) chk("t1_throughput", 128'(obs_cyc[5] - obs_cyc[0]), 128'(5));
      check_groups("t1");

      // Saturation at both rails.
      bias_bus = '0;
      for (int g = 0; g < NG; g++) begin
         bias_bus[18*(g*NT) +: 18]   = 18'h00200;
         bias_bus[18*(g*NT+1) +: 18] = 18'h3FF00;
      end
      clear_log();
      start_pass();
      send_beats(6, 0, 0, 1'b1);
      wait_idle();
      chk("t2_beats", 128'(obs.size()), 128'(6));
      if (obs.size() > 0) begin
         w = obs[0];
         chk("t2_pos_sat", 128'(w[17:0]), 128'(18'h1FFFF));
         chk("t2_neg_sat", 128'(w[35:18]), 128'(18'h20000));
         chk("t2_lane2", 128'(w[53:36]), 128'(18'h0));
      end

      // Backpressure mid-pass: out_ready low for 4 cycles.
      set_banks(18'd1, 18'h3FFFE);
      clear_log();
      start_pass();
      fork
         send_beats(6, 10, 10, 1'b0);
         begin
            repeat (2) tick();
            out_ready = 1'b0;
            repeat (4) tick();
            out_ready = 1'b1;
         end
      join
      wait_idle();
      chk("t3_beats", 128'(obs.size()), 128'(6));
      for (int k = 0; k < obs.size(); k++) begin
         w = obs[k];
         chk("t3_beat", 128'(w[17:0]), 128'(18'(10 + 10*k + ((k < 3) ? 1 : -2))));
      end
      check_groups("t3");

      // start pulsed during RUN and during FLUSH is ignored.
      clear_log();
      start_pass();
      fork
         send_beats(6, 1, 1, 1'b0);
         begin
            repeat (3) tick();
            start = 1'b1; tick(); start = 1'b0;
         end
      join
      chk("t4_flush_busy", 128'(busy), 128'(1));
      start = 1'b1; tick(); start = 1'b0;
      chk("t4_idle_after_flush", 128'(busy), 128'(0));
      check_groups("t4");
      chk("t4_beats", 128'(obs.size()), 128'(6));

      // Reset in the middle of group 1, then a fresh pass.
      clear_log();
      start_pass();
      send_beats(4, 7, 0, 1'b0);
      chk("t5_grp_before_rst", 128'(group_idx), 128'(1));
      rst = 1'b1; tick(); rst = 1'b0;
      chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
      chk("t5_rst_out_data", 128'(out_data), 128'(0));
      chk("t5_rst_busy", 128'(busy), 128'(0));
      chk("t5_rst_in_ready", 128'(in_ready), 128'(0));
      chk("t5_rst_group_idx", 128'(group_idx), 128'(0));
      clear_log();
      start_pass();
      chk("t5_restart_grp", 128'(group_idx), 128'(0));
      send_beats(6, 7, 0, 1'b0);
      wait_idle();
      check_groups("t5");
      for (int k = 0; k < obs.size(); k++)
         chk("t5_beat", 128'(obs[k]), (k < 3) ? 128'({NT{18'd8}}) : 128'({NT{18'd5}}));

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
